// File: rtl/ctrl_seq_unit.sv
// Decode and sequencing controller for the RV32I core datapath: decodes the opcode into datapath
// controls, stalls the PC on instruction or data-cache waits, and halts on an illegal opcode or a memory timeout.
module ctrl_seq_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             mem_done,
    output logic [2:0]       imm_sel,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             branch,
    output logic [1:0]       pc_sel,
    output logic [1:0]       result_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             pc_en,
    output logic             illegal,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        S_RUN,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_load, is_store, is_legal, dec_en;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign unused_instr_bits = ^{instr[31:15], instr[11:7]};
    assign is_load           = (opcode == OP_LOAD);
    assign is_store          = (opcode == OP_STORE);
    assign tmo_inc           = tmo_q + TMO_W'(1);

    always_comb begin
        case (opcode)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    end

    // The instruction is held stable by the datapath throughout MEM_WAIT, so it is decoded there too.
    assign dec_en = ((state_q == S_RUN) && instr_valid) || (state_q == S_MEM_WAIT);

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path can infer a latch.
        imm_sel     = 3'b000;
        alu_src     = 1'b0;
        alu_op      = 2'b00;
        branch      = 1'b0;
        pc_sel      = 2'b00;
        result_src  = 2'b00;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        pc_en       = 1'b0;
        state_d     = state_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        tmo_d       = tmo_q;

        if (dec_en) begin
            case (opcode)
                OP_R: alu_op = 2'b10;
                OP_IMM: begin
                    alu_src = 1'b1;
                    alu_op  = 2'b10;
                end
                OP_LOAD: begin
                    alu_src    = 1'b1;
                    result_src = 2'b01;
                    imm_sel    = (funct3 == 3'b100 || funct3 == 3'b101) ? 3'b101 : 3'b000;
                end
                OP_STORE: begin
                    imm_sel = 3'b001;
                    alu_src = 1'b1;
                end
                OP_BRANCH: begin
                    imm_sel = 3'b100;
                    alu_op  = 2'b01;
                    branch  = 1'b1;
                    pc_sel  = 2'b01;
                end
                OP_JAL: begin
                    imm_sel    = 3'b011;
                    pc_sel     = 2'b01;
                    result_src = 2'b10;
                end
                OP_JALR: begin
                    alu_src    = 1'b1;
                    pc_sel     = 2'b10;
                    result_src = 2'b10;
                end
                OP_LUI: begin
                    imm_sel    = 3'b010;
                    result_src = 2'b11;
                end
                OP_AUIPC: begin
                    imm_sel = 3'b010;
                    alu_src = 1'b1;
                end
                default: ;
            endcase
        end

        case (state_q)
            S_RUN: begin
                if (instr_valid) begin
                    if (!is_legal) begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end else if (is_load || is_store) begin
                        mem_read  = is_load;
                        mem_write = is_store;
                        tmo_d     = '0;
                        state_d   = S_MEM_WAIT;
                    end else begin
                        pc_en     = 1'b1;
                        reg_write = (opcode != OP_BRANCH);
                    end
                end
            end
            S_MEM_WAIT: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (mem_done) begin
                    pc_en     = 1'b1;
                    reg_write = is_load;
                    state_d   = S_RUN;
                end else begin
                    tmo_d = tmo_inc;
                    // The request stays up through the last wait cycle so a late mem_done still completes.
                    if (tmo_inc == TMO_W'(MEM_TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = S_HALT;
                    end
                end
            end
            default: ;
        endcase

        stall_d = stall_q;
        if (state_q != S_HALT && !pc_en && stall_q != '1) begin
            stall_d = stall_q + CNT_W'(1);
        end

        illegal     = illegal_q;
        mem_timeout = timeout_q;
        stall_cnt   = stall_q;

        // Reset forces every output low combinationally, so an in-flight access drops in the reset cycle itself.
        if (rst) begin
            imm_sel     = 3'b000;
            alu_src     = 1'b0;
            alu_op      = 2'b00;
            branch      = 1'b0;
            pc_sel      = 2'b00;
            result_src  = 2'b00;
            reg_write   = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            pc_en       = 1'b0;
            illegal     = 1'b0;
            mem_timeout = 1'b0;
            stall_cnt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= S_RUN;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            tmo_q     <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            tmo_q     <= tmo_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Directed self-checking bench for ctrl_seq_unit; a second instance with a 2-bit stall counter
// exercises counter saturation under the same stimulus.
module tb_ctrl_seq_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_done;

    logic [2:0]  imm_sel;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        branch;
    logic [1:0]  pc_sel;
    logic [1:0]  result_src;
    logic        reg_write, mem_read, mem_write, pc_en;
    logic        illegal, mem_timeout;
    logic [31:0] stall_cnt;

    logic [2:0]  unused_imm_sel;
    logic        unused_alu_src;
    logic [1:0]  unused_alu_op;
    logic        unused_branch;
    logic [1:0]  unused_pc_sel;
    logic [1:0]  unused_result_src;
    logic        unused_rw, unused_mr, unused_mw, unused_pe, unused_ill, unused_tmo;
    logic [1:0]  sat_cnt;

    int errors = 0;
    int checks = 0;

    // Control word: imm_sel, alu_src, alu_op, branch, pc_sel, result_src, reg_write, mem_read, mem_write, pc_en
    wire [14:0] ctl = {imm_sel, alu_src, alu_op, branch, pc_sel, result_src,
                       reg_write, mem_read, mem_write, pc_en};

    localparam logic [14:0] C_IDLE     = 15'b000_0_00_0_00_00_0_0_0_0;
    localparam logic [14:0] C_ADDI     = 15'b000_1_10_0_00_00_1_0_0_1;
    localparam logic [14:0] C_ADD      = 15'b000_0_10_0_00_00_1_0_0_1;
    localparam logic [14:0] C_JALR     = 15'b000_1_00_0_10_10_1_0_0_1;
    localparam logic [14:0] C_LW_REQ   = 15'b000_1_00_0_00_01_0_1_0_0;
    localparam logic [14:0] C_LW_DONE  = 15'b000_1_00_0_00_01_1_1_0_1;
    localparam logic [14:0] C_SW_REQ   = 15'b001_1_00_0_00_00_0_0_1_0;
    localparam logic [14:0] C_SW_DONE  = 15'b001_1_00_0_00_00_0_0_1_1;
    localparam logic [14:0] C_LUI      = 15'b010_0_00_0_00_11_1_0_0_1;
    localparam logic [14:0] C_AUIPC    = 15'b010_1_00_0_00_00_1_0_0_1;
    localparam logic [14:0] C_JAL      = 15'b011_0_00_0_01_10_1_0_0_1;
    localparam logic [14:0] C_BEQ      = 15'b100_0_01_1_01_00_0_0_0_1;
    localparam logic [14:0] C_LBU_REQ  = 15'b101_1_00_0_00_01_0_1_0_0;
    localparam logic [14:0] C_LBU_DONE = 15'b101_1_00_0_00_01_1_1_0_1;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_ADD   = 32'h0020_81B3;
    localparam logic [31:0] I_JALR  = 32'h0000_80E7;
    localparam logic [31:0] I_LW    = 32'h0000_A103;
    localparam logic [31:0] I_SW    = 32'h0020_A023;
    localparam logic [31:0] I_LUI   = 32'h1234_50B7;
    localparam logic [31:0] I_AUIPC = 32'h0000_1117;
    localparam logic [31:0] I_JAL   = 32'h0080_00EF;
    localparam logic [31:0] I_BEQ   = 32'h0020_8463;
    localparam logic [31:0] I_LBU   = 32'h0000_C183;
    localparam logic [31:0] I_ILL   = 32'h0000_007F;

    ctrl_seq_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .mem_done(mem_done),
        .imm_sel(imm_sel), .alu_src(alu_src), .alu_op(alu_op), .branch(branch), .pc_sel(pc_sel),
        .result_src(result_src), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .pc_en(pc_en), .illegal(illegal), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    ctrl_seq_unit #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .mem_done(mem_done),
        .imm_sel(unused_imm_sel), .alu_src(unused_alu_src), .alu_op(unused_alu_op),
        .branch(unused_branch), .pc_sel(unused_pc_sel), .result_src(unused_result_src),
        .reg_write(unused_rw), .mem_read(unused_mr), .mem_write(unused_mw), .pc_en(unused_pe),
        .illegal(unused_ill), .mem_timeout(unused_tmo), .stall_cnt(sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled 1-2 time units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic v, input logic d);
        instr       = i;
        instr_valid = v;
        mem_done    = d;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(I_ADDI, 1'b1, 1'b1);
        checks++;
        if (ctl !== C_IDLE || illegal !== 1'b0 || mem_timeout !== 1'b0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ctl=%b ill=%b tmo=%b cnt=%0d, want all zero",
                     ctl, illegal, mem_timeout, stall_cnt);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_alu();
        drive(I_ADDI, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_ADDI) begin errors++; $display("FAIL addi_ctl: got %b want %b", ctl, C_ADDI); end
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("FAIL addi_stall: got %0d want 0", stall_cnt); end
        tick();
        drive(I_ADD, 1'b1, 1'b1);  // stray mem_done in RUN must be ignored
        checks++;
        if (ctl !== C_ADD) begin errors++; $display("FAIL add_ctl: got %b want %b", ctl, C_ADD); end
        tick();
        drive(I_JALR, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_JALR) begin errors++; $display("FAIL jalr_ctl: got %b want %b", ctl, C_JALR); end
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(I_ADDI, 1'b0, 1'b0);
            checks++;
            if (ctl !== C_IDLE) begin errors++; $display("FAIL invalid_ctl: got %b want %b", ctl, C_IDLE); end
            tick();
        end
        drive(I_ADDI, 1'b1, 1'b0);
        checks++;
        if (stall_cnt !== 32'd2) begin errors++; $display("FAIL invalid_stall: got %0d want 2", stall_cnt); end
        tick();
    endtask

    task automatic test_load();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(I_LW, 1'b1, (c == 3));
            checks++;
            if (ctl !== ((c == 3) ? C_LW_DONE : C_LW_REQ)) begin
                errors++;
                $display("FAIL lw_cycle%0d: got %b want %b", c, ctl, (c == 3) ? C_LW_DONE : C_LW_REQ);
            end
            tick();
        end
        drive(I_ADDI, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_ADDI || stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL lw_after: ctl=%b cnt=%0d want %b cnt=3", ctl, stall_cnt, C_ADDI);
        end
        checks++;
        if (sat_cnt !== 2'd3) begin errors++; $display("FAIL sat_at3: got %0d want 3", sat_cnt); end
        tick();
        drive(I_ADDI, 1'b0, 1'b0);
        tick();
        drive(I_ADDI, 1'b1, 1'b0);
        checks++;
        if (stall_cnt !== 32'd4) begin errors++; $display("FAIL lw_stall4: got %0d want 4", stall_cnt); end
        checks++;
        if (sat_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d want 3", sat_cnt); end
        tick();
    endtask

    task automatic test_store();
        do_reset();
        drive(I_SW, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_SW_REQ) begin errors++; $display("FAIL sw_issue: got %b want %b", ctl, C_SW_REQ); end
        tick();
        drive(I_SW, 1'b1, 1'b1);
        checks++;
        if (ctl !== C_SW_DONE) begin errors++; $display("FAIL sw_done: got %b want %b", ctl, C_SW_DONE); end
        tick();
        drive(I_ADDI, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_ADDI || stall_cnt !== 32'd1) begin
            errors++;
            $display("FAIL sw_after: ctl=%b cnt=%0d want %b cnt=1", ctl, stall_cnt, C_ADDI);
        end
        tick();
    endtask

    task automatic test_imm_seq();
        logic [31:0] seq_i [4];
        logic [14:0] seq_c [4];
        seq_i = '{I_LUI, I_AUIPC, I_JAL, I_BEQ};
        seq_c = '{C_LUI, C_AUIPC, C_JAL, C_BEQ};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(seq_i[k], 1'b1, 1'b0);
            checks++;
            if (ctl !== seq_c[k]) begin
                errors++;
                $display("FAIL imm_seq%0d: got %b want %b", k, ctl, seq_c[k]);
            end
            tick();
        end
        drive(I_LBU, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_LBU_REQ) begin errors++; $display("FAIL lbu_issue: got %b want %b", ctl, C_LBU_REQ); end
        tick();
        drive(I_LBU, 1'b1, 1'b1);
        checks++;
        if (ctl !== C_LBU_DONE) begin errors++; $display("FAIL lbu_done: got %b want %b", ctl, C_LBU_DONE); end
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        drive(I_ILL, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_IDLE || illegal !== 1'b0) begin
            errors++;
            $display("FAIL ill_issue: ctl=%b ill=%b want %b ill=0", ctl, illegal, C_IDLE);
        end
        tick();
        for (int k = 0; k < 10; k++) begin
            drive(I_ADDI, 1'b1, 1'b1);
            checks++;
            if (ctl !== C_IDLE || illegal !== 1'b1 || stall_cnt !== 32'd1) begin
                errors++;
                $display("FAIL halt_cycle%0d: ctl=%b ill=%b cnt=%0d want %b ill=1 cnt=1",
                         k, ctl, illegal, stall_cnt, C_IDLE);
            end
            tick();
        end
        rst = 1'b1;
        drive(I_ADDI, 1'b1, 1'b0);
        checks++;
        if (illegal !== 1'b0 || ctl !== C_IDLE) begin
            errors++;
            $display("FAIL ill_rst: ill=%b ctl=%b want ill=0 %b", illegal, ctl, C_IDLE);
        end
        tick();
        rst = 1'b0;
        drive(I_ADDI, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_ADDI || illegal !== 1'b0) begin
            errors++;
            $display("FAIL ill_resume: ctl=%b ill=%b want %b ill=0", ctl, illegal, C_ADDI);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(I_LW, 1'b1, 1'b0);
            checks++;
            if (ctl !== C_LW_REQ || mem_timeout !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait%0d: ctl=%b tmo=%b want %b tmo=0", c, ctl, mem_timeout, C_LW_REQ);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(I_LW, 1'b1, 1'b1);
            checks++;
            if (ctl !== C_IDLE || mem_timeout !== 1'b1 || stall_cnt !== 32'd5) begin
                errors++;
                $display("FAIL tmo_halt%0d: ctl=%b tmo=%b cnt=%0d want %b tmo=1 cnt=5",
                         k, ctl, mem_timeout, stall_cnt, C_IDLE);
            end
            tick();
        end
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(I_LW, 1'b1, (c == 4));
            checks++;
            if (ctl !== ((c == 4) ? C_LW_DONE : C_LW_REQ)) begin
                errors++;
                $display("FAIL late_done%0d: got %b want %b", c, ctl, (c == 4) ? C_LW_DONE : C_LW_REQ);
            end
            tick();
        end
        drive(I_ADDI, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_ADDI || mem_timeout !== 1'b0 || stall_cnt !== 32'd4) begin
            errors++;
            $display("FAIL late_after: ctl=%b tmo=%b cnt=%0d want %b tmo=0 cnt=4",
                     ctl, mem_timeout, stall_cnt, C_ADDI);
        end
        tick();
    endtask

    task automatic test_rst_abort();
        do_reset();
        drive(I_SW, 1'b1, 1'b0);
        tick();
        drive(I_SW, 1'b1, 1'b0);
        checks++;
        if (mem_write !== 1'b1) begin errors++; $display("FAIL abort_pre: mem_write=%b want 1", mem_write); end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin errors++; $display("FAIL abort_drop: got %b want %b", ctl, C_IDLE); end
        tick();
        rst = 1'b0;
        drive(I_ADDI, 1'b1, 1'b0);
        checks++;
        if (ctl !== C_ADDI) begin errors++; $display("FAIL abort_resume: got %b want %b", ctl, C_ADDI); end
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        instr       = 32'h0;
        instr_valid = 1'b0;
        mem_done    = 1'b0;
        #2;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_imm_seq();
        test_illegal();
        test_timeout();
        test_rst_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
